// File: rtl/q_learning_pkg.sv
// Shared sizes, the stage-1 pipeline record and the board-to-row hash for the Q-learning updater.
// Latency: n/a (types and a pure function only).
// Backpressure: none; the pipeline advances on every clock edge.
package q_learning_pkg;

    localparam int N_ROWS    = 64;
    localparam int N_ACTIONS = 9;
    localparam int Q_W       = 8;
    localparam int STATE_W   = 18;
    localparam int ROW_W     = $clog2(N_ROWS);

    typedef logic [ROW_W-1:0]                row_t;
    typedef logic [N_ACTIONS-1:0][Q_W-1:0]   qrow_t;

    // Everything stage 2 needs, captured on the sampling edge.
    typedef struct packed {
        logic           vld;
        row_t           row;
        logic [3:0]     act;
        logic [Q_W-1:0] q;
        logic [Q_W-1:0] maxq;
        logic [Q_W-1:0] reward;
        logic [Q_W-1:0] gamma;
        logic [Q_W-1:0] alfa;
    } s1_t;

    // Fold the 9-cell board into a 6-bit row index.
    function automatic row_t row_hash(input logic [STATE_W-1:0] s);
        return s[5:0] ^ s[11:6] ^ s[17:12];
    endfunction

endpackage

// File: rtl/q_table.sv
// Q-table storage: 64 rows x 9 actions x 8 bits, two combinational full-row reads, one write.
// Latency: reads combinational, write visible after the clock edge.
// Backpressure: none; a write is taken on every edge where wr_en is high.
module q_table
    import q_learning_pkg::*;
(
    input  logic           clock,
    input  logic           reset,
    input  row_t           rd_row_a,
    output qrow_t          rd_dat_a,
    input  row_t           rd_row_b,
    output qrow_t          rd_dat_b,
    input  logic           wr_en,
    input  row_t           wr_row,
    input  logic [3:0]     wr_col,
    input  logic [Q_W-1:0] wr_dat
);

    qrow_t mem [N_ROWS];

    // Whole table clears on reset; otherwise one entry is written per edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < N_ROWS; r++) begin
                mem[r] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_row][wr_col] <= wr_dat;
        end
    end

    assign rd_dat_a = mem[rd_row_a];
    assign rd_dat_b = mem[rd_row_b];

endmodule

// File: rtl/q_learning.sv
// Two-stage Q-learning update: stage 1 reads Q(s,a) and max Q(s',*), stage 2 updates and writes back.
// Latency: 2 edges from input sampling to Q_new.
// Backpressure: none; inputs are sampled every edge, out-of-range actions are dropped.
module q_learning
    import q_learning_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic [3:0]         action,
    input  logic [STATE_W-1:0] state,
    input  logic [STATE_W-1:0] next_state,
    input  logic [7:0]         reward,
    input  logic [7:0]         gamma,
    input  logic [7:0]         alfa,
    output logic [Q_W-1:0]     Q_new
);

    s1_t                s1;
    s1_t                s1_nxt;
    row_t               row_s;
    row_t               row_ns;
    qrow_t              rd_s;
    qrow_t              rd_ns;
    logic [Q_W-1:0]     result;
    logic [Q_W-1:0]     disc_hi;
    logic [9:0]         target;
    logic signed [10:0] delta;
    logic signed [19:0] prod;
    logic signed [19:0] upd;
    logic signed [19:0] sum;

    assign row_s  = row_hash(state);
    assign row_ns = row_hash(next_state);

    q_table u_table (
        .clock    (clock),
        .reset    (reset),
        .rd_row_a (row_s),
        .rd_dat_a (rd_s),
        .rd_row_b (row_ns),
        .rd_dat_b (rd_ns),
        .wr_en    (s1.vld),
        .wr_row   (s1.row),
        .wr_col   (s1.act),
        .wr_dat   (result)
    );

    // Stage 2: target, signed error, floored scaled step, then clamp to 0..255.
    always_comb begin
        disc_hi = 8'((16'(s1.gamma) * 16'(s1.maxq)) >> 8);
        target  = {2'b00, s1.reward} + {2'b00, disc_hi};
        delta   = $signed({1'b0, target}) - $signed({3'b000, s1.q});
        prod    = $signed({12'd0, s1.alfa}) * $signed({{9{delta[10]}}, delta});
        upd     = prod >>> 8;
        sum     = $signed({12'd0, s1.q}) + upd;
        if (sum < 0) begin
            result = '0;
        end else if (sum > 20'sd255) begin
            result = '1;
        end else begin
            result = sum[Q_W-1:0];
        end
    end

    // Stage 1: table reads, forwarding the entry stage 2 writes on this same edge.
    always_comb begin
        logic           act_ok;
        logic [3:0]     act_idx;
        logic [Q_W-1:0] cand;
        act_ok  = (action <= 4'd8);
        act_idx = act_ok ? action : 4'd0;
        cand    = '0;
        s1_nxt        = '0;
        s1_nxt.vld    = act_ok;
        s1_nxt.row    = row_s;
        s1_nxt.act    = action;
        s1_nxt.reward = reward;
        s1_nxt.gamma  = gamma;
        s1_nxt.alfa   = alfa;
        if (s1.vld && s1.row == row_s && s1.act == act_idx) begin
            s1_nxt.q = result;
        end else begin
            s1_nxt.q = rd_s[act_idx];
        end
        for (int j = 0; j < N_ACTIONS; j++) begin
            if (s1.vld && s1.row == row_ns && s1.act == 4'(j)) begin
                cand = result;
            end else begin
                cand = rd_ns[j];
            end
            if (cand > s1_nxt.maxq) begin
                s1_nxt.maxq = cand;
            end
        end
    end

    // Pipeline registers; reset drops any update still in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1    <= '0;
            Q_new <= '0;
        end else begin
            s1 <= s1_nxt;
            if (s1.vld) begin
                Q_new <= result;
            end
        end
    end

endmodule

// File: tb/tb_q_learning.sv
// Randomized and directed bench for q_learning with a sequential reference model and scoreboard.
// Latency: expects Q_new two edges after an input is sampled.
// Backpressure: none; one transaction per clock.
module tb_q_learning;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  action = '0;
    logic [17:0] state = '0;
    logic [17:0] next_state = '0;
    logic [7:0]  reward = '0;
    logic [7:0]  gamma = '0;
    logic [7:0]  alfa = '0;
    logic [7:0]  Q_new;

    q_learning dut (
        .clock      (clock),
        .reset      (reset),
        .action     (action),
        .state      (state),
        .next_state (next_state),
        .reward     (reward),
        .gamma      (gamma),
        .alfa       (alfa),
        .Q_new      (Q_new)
    );

    always #5 clock = ~clock;

    typedef struct {
        int    at;
        int    val;
        string nm;
    } exp_t;

    exp_t exp_q[$];
    int   tbl[64][9];
    int   model_q  = 0;
    int   cyc      = 0;
    int   last_at  = 0;
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input int actual, input int required);
        n_checks++;
        if (actual == required) begin
            n_pass++;
        end else begin
            $display("FAIL %s: Q_new=%0d expected %0d at edge %0d", name, actual, required, cyc);
        end
    endtask

    function automatic int hash(input int s);
        return (s & 63) ^ ((s >> 6) & 63) ^ ((s >> 12) & 63);
    endfunction

    // Transactions applied strictly in order, each reading the table left by all earlier ones.
    function automatic void model_txn(input int a, input int s, input int ns,
                                       input int rw, input int g, input int al);
        int rs, rn, q, mx, target, delta, p, upd, res;
        if (a > 8) return;
        rs = hash(s);
        rn = hash(ns);
        q  = tbl[rs][a];
        mx = 0;
        for (int j = 0; j < 9; j++) if (tbl[rn][j] > mx) mx = tbl[rn][j];
        target = rw + (g * mx) / 256;
        delta  = target - q;
        p      = al * delta;
        upd    = (p >= 0) ? p / 256 : -((-p + 255) / 256);
        res    = q + upd;
        if (res < 0)   res = 0;
        if (res > 255) res = 255;
        tbl[rs][a] = res;
        model_q    = res;
    endfunction

    function automatic void push(input int at, input int val, input string nm);
        exp_q.push_back('{at, val, nm});
        last_at = at;
    endfunction

    // One clock of stimulus, driven on the falling edge.
    task automatic step(input bit r, input int a, input int s, input int ns,
                        input int rw, input int g, input int al, input string name);
        @(negedge clock);
        if (r) begin
            reset = 1'b1;
            exp_q.delete();
            for (int i = 0; i < 64; i++) for (int j = 0; j < 9; j++) tbl[i][j] = 0;
            model_q = 0;
            push(cyc + 1, 0, name);
            #1;
            check({name, "_now"}, int'(Q_new), 0);
        end else begin
            reset      = 1'b0;
            action     = 4'(a);
            state      = 18'(s);
            next_state = 18'(ns);
            reward     = 8'(rw);
            gamma      = 8'(g);
            alfa       = 8'(al);
            if (last_at < cyc + 1) push(cyc + 1, model_q, name);
            model_txn(a, s, ns, rw, g, al);
            push(cyc + 2, model_q, name);
        end
    endtask

    task automatic readback(input string name);
        for (int r = 0; r < 64; r++) begin
            for (int a = 0; a < 9; a++) begin
                step(0, a, r, r, 0, 0, 0, name);
            end
        end
    endtask

    // Monitor: compares every expectation due at the edge just passed.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            cyc++;
            #2;
            while (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
                e = exp_q.pop_front();
                check(e.nm, int'(Q_new), e.val);
            end
        end
    end

    initial begin
        int a, s, ns;
        for (int i = 0; i < 64; i++) for (int j = 0; j < 9; j++) tbl[i][j] = 0;

        repeat (2) step(1, 0, 0, 0, 0, 0, 0, "reset");
        repeat (5) step(0, 2, 0, 3, 2, 2, 2, "floor_zero");

        step(1, 0, 0, 0, 0, 0, 0, "reset2");
        repeat (5) step(0, 2, 0, 0, 100, 0, 128, "bypass_chain");

        repeat (3) step(0, 4, 5, 9, 201, 0, 255, "train200");
        step(0, 4, 5, 9, 0, 0, 128, "neg_floor");

        repeat (2) step(0, 1, 7, 7, 255, 0, 255, "sat_a");
        repeat (3) step(0, 1, 7, 7, 255, 255, 255, "sat_b");

        repeat (3) step(0, 12, 5, 7, 255, 255, 255, "bad_action");
        readback("readback");

        for (int k = 0; k < 400; k++) begin
            s  = $urandom_range(0, 1) ? int'($urandom_range(0, 3)) : int'($urandom & 32'h3ffff);
            ns = $urandom_range(0, 1) ? int'($urandom_range(0, 3)) : int'($urandom & 32'h3ffff);
            a  = int'($urandom_range(0, 11));
            if ($urandom_range(0, 49) == 0) begin
                step(1, 0, 0, 0, 0, 0, 0, "rand_rst");
            end else begin
                step(0, a, s, ns, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                     int'($urandom_range(0, 255)), "random");
            end
        end

        repeat (2) step(0, 2, 0, 0, 100, 0, 128, "pre_rst");
        step(1, 0, 0, 0, 0, 0, 0, "mid_rst");
        readback("zero_readback");

        repeat (3) step(0, 15, 0, 0, 0, 0, 0, "flush");
        repeat (2) @(posedge clock);
        #3;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
